fetch_unit: RTL and testbench

Instruction fetch and sequencing block that produces the 9-bit `inst` word consumed by `control` and acts on the `branch_en` decision that `control` returns. It holds the program counter, a 32-entry branch-target lookup table indexed by `inst[4:0]`, and a run/halt state machine. It sits between instruction memory and `control` and issues one instruction per cycle.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_if.sv | 27 ++
 rtl/branch_lut.sv | 25 ++
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch unit
package fetch_pkg;
  localparam int INST_W    = 9;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_IDX_W = 5;

  localparam logic [INST_W-1:0] NOP_INST = 9'b1_1010_0000;
  localparam logic [3:0]        HALT_OP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch unit bus: instruction memory, control handshake and branch-LUT write port
interface fetch_if import fetch_pkg::*; #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) ();
  logic                 start;
  logic [PC_W-1:0]      imem_addr;
  logic [INST_W-1:0]    imem_data;
  logic                 branch_en;
  logic [INST_W-1:0]    inst;
  logic                 inst_valid;
  logic                 done;
  logic [CNT_W-1:0]     retired;
  logic                 lut_we;
  logic [LUT_IDX_W-1:0] lut_idx;
  logic [PC_W-1:0]      lut_data;

  modport master (
    input  start, imem_data, branch_en, lut_we, lut_idx, lut_data,
    output imem_addr, inst, inst_valid, done, retired
  );

  modport slave (
    output start, imem_data, branch_en, lut_we, lut_idx, lut_data,
    input  imem_addr, inst, inst_valid, done, retired
  );
endinterface

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - 32-entry branch-target register file, sync write, comb read, async clear
module branch_lut import fetch_pkg::*; #(
  parameter int PC_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] wr_idx,
  input  logic [PC_W-1:0]      wr_data,
  input  logic [LUT_IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]      rd_data
);
  logic [PC_W-1:0] entries [LUT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) entries[i] <= '0;
    end else if (we) begin
      entries[wr_idx] <= wr_data;
    end
  end

  // A same-cycle write lands at the edge, so a concurrent branch sees the old target.
  assign rd_data = entries[rd_idx];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, run/halt sequencing and retired-instruction counter
module fetch_unit import fetch_pkg::*; #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic  clk,
  input  logic  reset,
  fetch_if.master bus
);
  state_t             state, state_n;
  logic [PC_W-1:0]    pc, pc_n, lut_target;
  logic [CNT_W-1:0]   retired, retired_n;
  logic [INST_W-1:0]  inst;

  branch_lut #(.PC_W(PC_W)) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.lut_we),
    .wr_idx  (bus.lut_idx),
    .wr_data (bus.lut_data),
    .rd_idx  (inst[LUT_IDX_W-1:0]),
    .rd_data (lut_target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      retired <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      retired <= retired_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    retired_n = retired;
    inst      = NOP_INST;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n   = RUN;
          pc_n      = '0;
          retired_n = '0;
        end
      end
      RUN: begin
        inst = bus.imem_data;
        // HALT wins over any branch decision and is not counted.
        if (inst[INST_W-1 -: 4] == HALT_OP) begin
          state_n = DONE;
        end else begin
          pc_n = bus.branch_en ? lut_target : pc + PC_W'(1);
          if (retired != '1) retired_n = retired + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.imem_addr  = pc;
  assign bus.inst       = inst;
  assign bus.inst_valid = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.retired    = retired;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed scenarios and random traffic
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << PC_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [8:0] mem [DEPTH];
  bit         br  [DEPTH];
  assign bus.imem_data = mem[bus.imem_addr];

  typedef struct {
    int addr;
    int inst;
    bit valid;
    bit done;
    int retired;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: program counter, run/finished flags, counter and LUT contents.
  bit running, finished;
  int m_pc, m_retired;
  int m_lut [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("imem_addr",  32'(bus.imem_addr),  e.addr);
      check("inst",       32'(bus.inst),       e.inst);
      check("inst_valid", 32'(bus.inst_valid), 32'(e.valid));
      check("done",       32'(bus.done),       32'(e.done));
      check("retired",    32'(bus.retired),    e.retired);
    end
  end

  function automatic logic [8:0] rand_op();
    return 9'($urandom_range(0, 479));
  endfunction

  function automatic logic [8:0] halt_op();
    return 9'(480 + $urandom_range(0, 31));
  endfunction

  task automatic model_clear();
    running = 0; finished = 0; m_pc = 0; m_retired = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
  endtask

  // Drive inputs for the coming edge, advance the model and queue the expected outputs.
  task automatic step(input bit st, input bit we, input int idx, input int data);
    logic [8:0] ci;
    bit b;
    b = br[m_pc];
    bus.start     = st;
    bus.lut_we    = we;
    bus.lut_idx   = 5'(idx);
    bus.lut_data  = 10'(data);
    bus.branch_en = b;
    if (running) begin
      ci = mem[m_pc];
      if (ci[8:5] == 4'hF) begin
        running = 0; finished = 1;
      end else begin
        m_pc = b ? m_lut[ci[4:0]] : (m_pc + 1) % DEPTH;
        if (m_retired < CMAX) m_retired++;
      end
    end else if (st) begin
      running = 1; finished = 0; m_pc = 0; m_retired = 0;
    end
    if (we) m_lut[idx] = data;
    q.push_back('{m_pc, running ? int'(mem[m_pc]) : int'(NOP_INST), running, finished, m_retired});
  endtask

  task automatic win();
    @(negedge clk);
    #1;
  endtask

  task automatic tick(input bit st, input bit we, input int idx, input int data);
    win();
    step(st, we, idx, data);
  endtask

  task automatic reset_checks();
    check("rst_imem_addr",  32'(bus.imem_addr),  0);
    check("rst_inst",       32'(bus.inst),       32'(NOP_INST));
    check("rst_inst_valid", 32'(bus.inst_valid), 0);
    check("rst_done",       32'(bus.done),       0);
    check("rst_retired",    32'(bus.retired),    0);
  endtask

  // Called inside a window; the caller follows with step() before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset_checks();
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.lut_we = 0; bus.lut_idx = 0; bus.lut_data = 0; bus.branch_en = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = rand_op();
      br[i]  = 0;
    end
    model_clear();
    #2;
    reset_checks();
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0);

    // Straight-line program ending in HALT; HALT carries a branch request that must lose.
    mem[3] = halt_op(); br[3] = 1;
    tick(1, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    win();
    check("s1_retired", 32'(bus.retired), 3);
    check("s1_done", 32'(bus.done), 1);
    check("s1_addr", 32'(bus.imem_addr), 3);
    step(0, 0, 0, 0);

    // Taken and not-taken branch on key 5.
    mem[3] = rand_op(); br[3] = 0;
    mem[2] = {4'h3, 5'd5}; br[2] = 1; mem[40] = halt_op();
    tick(0, 1, 5, 40);
    tick(1, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    win();
    check("s2_taken_addr", 32'(bus.imem_addr), 40);
    br[2] = 0; mem[3] = halt_op();
    step(1, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    win();
    check("s2_fall_addr", 32'(bus.imem_addr), 3);
    step(0, 0, 0, 0);

    // PC wrap from 1023 to 0.
    mem[3] = rand_op();
    mem[0] = {4'h2, 5'd1}; br[0] = 1; mem[1023] = rand_op(); br[1023] = 0;
    tick(0, 1, 1, 1023);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    win();
    check("s3_wrap_addr", 32'(bus.imem_addr), 0);
    br[0] = 0; mem[1] = halt_op();
    step(0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);

    // Same-cycle write and branch on key 7: old target first, new target next time.
    mem[1] = rand_op(); mem[0] = rand_op();
    mem[2] = {4'h1, 5'd7}; br[2] = 1;
    mem[20] = {4'h1, 5'd7}; br[20] = 1; mem[100] = halt_op();
    tick(0, 1, 7, 20);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 7, 100);
    win();
    check("s4_old_target", 32'(bus.imem_addr), 20);
    step(0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    win();
    check("s4_new_target", 32'(bus.imem_addr), 100);
    step(0, 0, 0, 0);

    // Reset mid-RUN at PC 17 with ignored start pulses; LUT must come back cleared.
    mem[0] = {4'h2, 5'd3}; br[0] = 1; mem[17] = {4'h2, 5'd3}; br[17] = 1;
    tick(0, 1, 3, 17);
    tick(1, 0, 0, 0);
    repeat (5) tick(1, 0, 0, 0);
    win();
    check("s5_pre_reset_addr", 32'(bus.imem_addr), 17);
    do_reset();
    step(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    win();
    check("s5_cleared_lut_addr", 32'(bus.imem_addr), 0);
    br[0] = 0; mem[1] = halt_op();
    step(0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);

    // Restart from DONE, then a 70000-instruction self-loop saturates the counter.
    mem[0] = {4'h4, 5'd0}; br[0] = 1;
    tick(1, 0, 0, 0);
    win();
    check("s6_restart_done", 32'(bus.done), 0);
    check("s6_restart_retired", 32'(bus.retired), 0);
    step(0, 0, 0, 0);
    repeat (70000) tick(($urandom % 4) == 0, 0, 0, 0);
    br[0] = 0;
    repeat (3) tick(0, 0, 0, 0);
    win();
    check("s6_saturated", 32'(bus.retired), CMAX);
    check("s6_done", 32'(bus.done), 1);
    step(0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = (($urandom % 20) == 0) ? halt_op() : rand_op();
      br[i]  = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      win();
      if (($urandom % 400) == 0) do_reset();
      br[m_pc] = bit'($urandom % 2);
      step(($urandom % 8) == 0, ($urandom % 4) == 0, int'($urandom % 32), int'($urandom % DEPTH));
    end

    win();
    check("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
